// File: rtl/text_pkg.sv
// Shared text definitions: character codes, table geometry defaults,
// the menu string table and the streamer state encoding.
// Optional build macro: STR_PACE_EN adds the PACE state.
package text_pkg;

  localparam int DEF_CHAR_WIDTH = 5;
  localparam int DEF_MAX_CHAR   = 11;
  localparam int DEF_STRING_NUM = 7;
  localparam int DEF_STR_W      = DEF_CHAR_WIDTH * DEF_MAX_CHAR;

  typedef logic [DEF_CHAR_WIDTH-1:0] char_t;

  localparam char_t CHAR_A = 5'd0,  CHAR_B = 5'd1,  CHAR_C = 5'd2,  CHAR_D = 5'd3;
  localparam char_t CHAR_E = 5'd4,  CHAR_F = 5'd5,  CHAR_G = 5'd6,  CHAR_H = 5'd7;
  localparam char_t CHAR_I = 5'd8,  CHAR_J = 5'd9,  CHAR_K = 5'd10, CHAR_L = 5'd11;
  localparam char_t CHAR_M = 5'd12, CHAR_N = 5'd13, CHAR_O = 5'd14, CHAR_P = 5'd15;
  localparam char_t CHAR_Q = 5'd16, CHAR_R = 5'd17, CHAR_S = 5'd18, CHAR_T = 5'd19;
  localparam char_t CHAR_U = 5'd20, CHAR_V = 5'd21, CHAR_W = 5'd22, CHAR_X = 5'd23;
  localparam char_t CHAR_Y = 5'd24, CHAR_Z = 5'd25;
  localparam char_t CHAR_COLON = 5'd26;
  localparam char_t CHAR_SPACE = 5'd28;

  // Character 0 of each string sits in the most-significant bits.
  localparam logic [DEF_STR_W-1:0] MENU_S0 = {CHAR_G, CHAR_A, CHAR_M, CHAR_E, CHAR_SPACE,
      CHAR_T, CHAR_I, CHAR_M, CHAR_E, CHAR_COLON, CHAR_SPACE};
  localparam logic [DEF_STR_W-1:0] MENU_S1 = {CHAR_N, CHAR_E, CHAR_W, CHAR_SPACE, CHAR_G,
      CHAR_A, CHAR_M, CHAR_E, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
  localparam logic [DEF_STR_W-1:0] MENU_S2 = {CHAR_H, CHAR_I, CHAR_G, CHAR_H, CHAR_SPACE,
      CHAR_S, CHAR_C, CHAR_O, CHAR_R, CHAR_E, CHAR_SPACE};
  localparam logic [DEF_STR_W-1:0] MENU_S3 = {CHAR_O, CHAR_P, CHAR_T, CHAR_I, CHAR_O,
      CHAR_N, CHAR_S, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
  localparam logic [DEF_STR_W-1:0] MENU_S4 = {CHAR_S, CHAR_O, CHAR_U, CHAR_N, CHAR_D,
      CHAR_SPACE, CHAR_O, CHAR_N, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
  localparam logic [DEF_STR_W-1:0] MENU_S5 = {CHAR_P, CHAR_A, CHAR_U, CHAR_S, CHAR_E,
      CHAR_D, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
  localparam logic [DEF_STR_W-1:0] MENU_S6 = {CHAR_G, CHAR_A, CHAR_M, CHAR_E, CHAR_SPACE,
      CHAR_S, CHAR_T, CHAR_A, CHAR_T, CHAR_U, CHAR_S};

  // String k occupies slice [k*DEF_STR_W +: DEF_STR_W].
  localparam logic [DEF_STR_W*DEF_STRING_NUM-1:0] MENU_STR_INIT =
      {MENU_S6, MENU_S5, MENU_S4, MENU_S3, MENU_S2, MENU_S1, MENU_S0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
`ifdef STR_PACE_EN
    ST_STREAM = 2'd2,
    ST_PACE   = 2'd3
`else
    ST_STREAM = 2'd2
`endif
  } str_state_e;

endpackage

// File: rtl/string_table_rom.sv
// Read-only string table with a registered read port. The read register
// doubles as the stream shadow: it only loads when a request is accepted,
// so later req_idx changes never disturb a string already in flight.
module string_table_rom
  import text_pkg::*;
#(
  parameter int CHAR_WIDTH = DEF_CHAR_WIDTH,
  parameter int MAX_CHAR   = DEF_MAX_CHAR,
  parameter int STRING_NUM = DEF_STRING_NUM,
  parameter logic [CHAR_WIDTH*MAX_CHAR*STRING_NUM-1:0] STR_INIT = MENU_STR_INIT,
  parameter int IDX_W      = $clog2(STRING_NUM + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_en,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [CHAR_WIDTH*MAX_CHAR-1:0] rd_data
);

  localparam int STR_W = CHAR_WIDTH * MAX_CHAR;

  // Capture the selected string on an accepted request, hold it otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= {STR_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= STR_INIT[int'(rd_idx) * STR_W +: STR_W];
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/string_streamer.sv
// Serialises one string of the menu table as a valid/ready character stream,
// with optional trailing-space trim.
// Optional build macro: STR_PACE_EN adds pace_div and idle gaps between beats.
module string_streamer
  import text_pkg::*;
#(
  parameter int CHAR_WIDTH = DEF_CHAR_WIDTH,
  parameter int MAX_CHAR   = DEF_MAX_CHAR,
  parameter int STRING_NUM = DEF_STRING_NUM,
  parameter logic [CHAR_WIDTH*MAX_CHAR*STRING_NUM-1:0] STR_INIT = MENU_STR_INIT,
  parameter logic [CHAR_WIDTH-1:0] SPACE_CODE = CHAR_SPACE,
  parameter int PACE_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [$clog2(STRING_NUM+1)-1:0] req_idx,
  input  logic                           trim_en,
  input  logic                           abort,
  output logic                           char_valid,
  input  logic                           char_ready,
`ifdef STR_PACE_EN
  input  logic [PACE_W-1:0]              pace_div,
`endif
  output logic [CHAR_WIDTH-1:0]          char_code,
  output logic [$clog2(MAX_CHAR)-1:0]    char_pos,
  output logic                           char_last,
  output logic                           req_err,
  output logic                           busy
);

  localparam int STR_W = CHAR_WIDTH * MAX_CHAR;
  localparam int IDX_W = $clog2(STRING_NUM + 1);
  localparam int POS_W = $clog2(MAX_CHAR);
  localparam int LEN_W = $clog2(MAX_CHAR + 1);

  str_state_e        state_r, state_s;
  logic [POS_W-1:0]  pos_r, pos_s;
  logic [LEN_W-1:0]  len_r, len_s, load_len_s;
  logic              trim_r, trim_s;
  logic              rd_en_s, accept_s, present_s;
  logic [STR_W-1:0]  shadow_s;
  logic              valid_s, last_s, err_s;
  logic [CHAR_WIDTH-1:0] code_s;
  logic [POS_W-1:0]  cpos_s;
`ifdef STR_PACE_EN
  logic [PACE_W-1:0] pace_cnt_r, pace_cnt_s;
`endif

  function automatic logic [CHAR_WIDTH-1:0] char_at(input logic [STR_W-1:0] s,
                                                    input logic [POS_W-1:0] p);
    return s[(MAX_CHAR - 1 - int'(p)) * CHAR_WIDTH +: CHAR_WIDTH];
  endfunction

  function automatic logic is_last(input logic [POS_W-1:0] p, input logic [LEN_W-1:0] l);
    return (LEN_W'(p) + LEN_W'(1'b1)) == l;
  endfunction

  string_table_rom #(
    .CHAR_WIDTH (CHAR_WIDTH),
    .MAX_CHAR   (MAX_CHAR),
    .STRING_NUM (STRING_NUM),
    .STR_INIT   (STR_INIT),
    .IDX_W      (IDX_W)
  ) u_rom (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en_s),
    .rd_idx  (req_idx),
    .rd_data (shadow_s)
  );

  // Stream length: full slot, or up to the last non-space character when trimming.
  always_comb begin
    load_len_s = trim_r ? LEN_W'(1'b1) : LEN_W'(MAX_CHAR);
    for (int i = 0; i < MAX_CHAR; i++) begin
      if (trim_r && (shadow_s[(MAX_CHAR - 1 - i) * CHAR_WIDTH +: CHAR_WIDTH] != SPACE_CODE)) begin
        load_len_s = LEN_W'(i + 1);
      end else begin
        load_len_s = load_len_s;
      end
    end
  end

  // Next-state logic and next values for the registered outputs.
  always_comb begin
    state_s   = state_r;
    pos_s     = pos_r;
    len_s     = len_r;
    trim_s    = trim_r;
    rd_en_s   = 1'b0;
    present_s = 1'b0;
    accept_s  = char_valid && char_ready;
    valid_s   = 1'b0;
    code_s    = char_code;
    cpos_s    = char_pos;
    last_s    = 1'b0;
    err_s     = 1'b0;
`ifdef STR_PACE_EN
    pace_cnt_s = pace_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_idx < IDX_W'(STRING_NUM)) begin
            state_s = ST_LOAD;
            trim_s  = trim_en;
            rd_en_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else begin
          state_s   = ST_STREAM;
          pos_s     = {POS_W{1'b0}};
          len_s     = load_len_s;
          present_s = 1'b1;
        end
      end
      ST_STREAM: begin
        // Accepting the last beat completes the string even under abort.
        if (accept_s && char_last) begin
          state_s = ST_IDLE;
        end else if (abort) begin
          state_s = ST_IDLE;
        end else if (accept_s) begin
          pos_s = pos_r + 1'b1;
`ifdef STR_PACE_EN
          if (pace_div != {PACE_W{1'b0}}) begin
            state_s    = ST_PACE;
            pace_cnt_s = pace_div;
          end else begin
            present_s = 1'b1;
          end
`else
          present_s = 1'b1;
`endif
        end else begin
          present_s = 1'b1;
        end
      end
`ifdef STR_PACE_EN
      ST_PACE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (pace_cnt_r == PACE_W'(1'b1)) begin
          state_s   = ST_STREAM;
          present_s = 1'b1;
        end else begin
          pace_cnt_s = pace_cnt_r - 1'b1;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (present_s) begin
      valid_s = 1'b1;
      code_s  = char_at(shadow_s, pos_s);
      cpos_s  = pos_s;
      last_s  = is_last(pos_s, len_s);
    end else begin
      valid_s = 1'b0;
    end
  end

  // State and stream bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pos_r   <= {POS_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      trim_r  <= 1'b0;
`ifdef STR_PACE_EN
      pace_cnt_r <= {PACE_W{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      pos_r   <= pos_s;
      len_r   <= len_s;
      trim_r  <= trim_s;
`ifdef STR_PACE_EN
      pace_cnt_r <= pace_cnt_s;
`endif
    end
  end

  // Registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= {CHAR_WIDTH{1'b0}};
      char_pos   <= {POS_W{1'b0}};
      char_last  <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      req_ready  <= (state_s == ST_IDLE);
      busy       <= (state_s != ST_IDLE);
      char_valid <= valid_s;
      char_code  <= code_s;
      char_pos   <= cpos_s;
      char_last  <= last_s;
      req_err    <= err_s;
    end
  end

endmodule

// File: doc/string_streamer.md
Name: string_streamer

Overview:
- Parametrised successor to the combinational string table. Holds STRING_NUM strings of MAX_CHAR characters each.
- On a request, it serialises the selected string as a stream of CHAR_WIDTH-bit character codes over a valid/ready handshake.
- Optional trailing-space trim and per-character pacing.
- Sits between the menu/status controller and the text renderer, so the renderer no longer needs a full-width string bus.

Parameters:
- CHAR_WIDTH, 5, bits per character code.
- MAX_CHAR, 11, characters per string slot.
- STRING_NUM, 7, number of strings in the table.
- STR_INIT, pkg MENU_STR_INIT, table contents, CHAR_WIDTH*MAX_CHAR*STRING_NUM bits.
  - String k occupies slice [k*CHAR_WIDTH*MAX_CHAR +: CHAR_WIDTH*MAX_CHAR].
  - Character 0 is the most-significant CHAR_WIDTH bits of the slice.
- SPACE_CODE, 28, code treated as blank for trimming.
- PACE_W, 8, width of the pacing counter (used only with STR_PACE_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  string request.
- req_ready  out  1  high only in IDLE.
- req_idx  in  $clog2(STRING_NUM+1)  string index.
- trim_en  in  1  sampled with the request; drop trailing SPACE_CODE characters.
- abort  in  1  cancel the current stream.
- char_valid  out  1  character beat valid.
- char_ready  in  1  consumer accepts beat.
- char_code  out  CHAR_WIDTH  character code.
- char_pos  out  $clog2(MAX_CHAR)  index of the character within the string.
- char_last  out  1  final beat of the string.
- req_err  out  1  one-cycle pulse when req_idx >= STRING_NUM.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State returns to IDLE.
  - req_ready=1; char_valid, char_last, req_err and busy =0; char_code and char_pos =0.
  - Reset overrides everything, including a stream in progress.
- States: IDLE, LOAD, STREAM; PACE only when STR_PACE_EN is defined.
- IDLE:
  - A handshake (req_valid & req_ready) with idx < STRING_NUM moves to LOAD. The string and trim_en are latched into a shadow register.
  - idx >= STRING_NUM: req_err pulses the next cycle and the state stays IDLE.
- LOAD (1 cycle):
  - Computes the stream length len.
  - Without trim, len = MAX_CHAR.
  - With trim, len = (highest position holding a non-space character) + 1.
  - An all-space string with trim gives len=1, i.e. a single SPACE beat.
  - Goes to STREAM with pos=0.
- Latency: request accepted at cycle N; first char_valid at cycle N+2.
- STREAM:
  - char_valid=1, char_code = shadow[pos], char_pos = pos, char_last = (pos == len-1).
  - Outputs hold stable while char_ready=0.
  - On accept: if last, go to IDLE (req_ready=1 the next cycle); otherwise pos+1.
- Throughput: one character per cycle while char_ready=1. No back-to-back string overlap; the request after a completed stream is accepted no earlier than the cycle after the last beat.
- abort:
  - In LOAD, STREAM or PACE: next state IDLE, char_valid=0 the next cycle, no char_last is emitted.
  - Abort and acceptance of the last beat in the same cycle: treated as a completed stream.
  - Abort in IDLE: ignored; a simultaneous request is still accepted.
- The table is read-only and not writable at runtime. The shadow register isolates the stream from req_idx changes.

Optional Feature:
- Macro STR_PACE_EN.
- When defined:
  - Adds input pace_div [PACE_W-1:0].
  - After each accepted non-last beat, the block enters PACE and holds char_valid=0 for pace_div cycles before presenting the next character.
  - pace_div=0 behaves as if undefined.
  - pace_div is sampled at each beat acceptance.
- When undefined: no PACE state and no pace_div port; characters are back-to-back.

Decomposition:
- Shared package text_pkg holds:
  - character code constants (CHAR_A=0 … CHAR_Z=25, CHAR_COLON=26, CHAR_SPACE=28);
  - CHAR_WIDTH and MAX_CHAR defaults;
  - MENU_STR_INIT;
  - the state enum.
- One sub-module: string_table_rom, holding the registered table read that feeds the shadow register. Trim logic and FSM stay in string_streamer.

Test Plan:
1. Reset, then req idx=6, trim_en=0, char_ready=1 -> first char_valid at N+2. 11 beats with codes 6,0,12,4,28,18,19,0,19,20,18; char_last on pos 10.
2. Req idx=0, trim_en=1 -> 10 beats with codes 6,0,12,4,28,19,8,12,4,26; char_last at pos 9; the trailing 28 is dropped.
3. Req idx=0 with char_ready toggling 1,0,0,1… -> char_code and char_pos stable while stalled; no lost or duplicated beat.
4. Req idx=7 -> req_err high exactly 1 cycle, no char_valid, req_ready stays 1.
5. abort at pos 3 of idx 5 -> char_valid=0 next cycle, no char_last; a new request is accepted the cycle after.
6. Table override with an all-28 string, trim_en=1 -> single beat with code 28 and char_last=1. With STR_PACE_EN and pace_div=3: exactly 3 idle cycles between beats.
